calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Sequential replacement for the combinational frequency/duty/phase math. On START (end of a gate
//  period) it snapshots the four counter results and runs three ops in order through one shared
//  64/32 serial divider: frequency, duty, phase. All three results commit together; SEL picks DATA.
//  Sits between the gate counters and the display driver.
// PARAMETERS
//  W            32           counter/result width
//  REF_HZ       100_000_000  reference clock of counter Q1 (frequency scale)
//  DUTY_SCALE   1000         duty units: 0.1 % (500 = 50.0 %)
//  PHASE_SCALE  180          phase numerator scale (degrees)
// PORTS
//  CLK    in   1   system clock, all logic on rising edge
//  RST    in   1   synchronous, active-high reset
//  START  in   1   1-cycle pulse: Q1..Q4 valid and stable this cycle
//  Q1     in   W   reference-clock count over gate
//  Q2     in   W   signal-edge count over gate
//  Q3     in   W   high-time count (ref clocks)
//  Q4     in   W   phase-offset count (ref clocks)
//  SEL    in   2   3=frequency, 1=duty, 2=phase, 0=zero
//  DATA   out  W   selected committed result, registered
//  BUSY   out  1   high while a computation is in progress
//  VALID  out  1   1-cycle pulse: new results committed
//  DIV0   out  3   per-op divide-by-zero flag [0]=freq [1]=duty [2]=phase, held with results
// BEHAVIOUR
//  Reset: DATA=0, BUSY=0, VALID=0, DIV0=0, committed and working results=0, FSM=IDLE, op=0.
//  Ops: op0 freq = REF_HZ*Q2/Q1; op1 duty = DUTY_SCALE*Q3/Q1; op2 phase = PHASE_SCALE*Q4/Q3.
//  FSM: IDLE -START-> MUL (snapshot Q1..Q4, op=0, BUSY=1 from next cycle).
//   MUL (1 cyc): numerator = scale*operand, 64-bit unsigned. Divisor=0 -> STORE, div0 flag set.
//   DIV (64 cyc): restoring divide, one quotient bit per cycle, MSB first.
//   STORE (1 cyc): quotient[63:32]!=0 -> working result = {W{1'b1}} (saturate), else quotient[31:0];
//     div0 -> result 0. op<2: op++ -> MUL; op==2 -> COMMIT.
//   COMMIT (1 cyc): working results and flags copied to committed regs; VALID=1; -> IDLE, BUSY=0.
//  Latency: no div0 -> VALID in cycle 199 after the START-sampling edge (3*66 + 1);
//   each div0 op shortens by 64 cycles.
//  START while not IDLE: ignored. No queueing. Snapshot protects against Q changes mid-run.
//  START in IDLE in the same cycle as RST: RST wins.
//  RST mid-run: immediate return to reset state; committed results cleared, no VALID.
//  DATA = mux(SEL, committed) registered: 1-cycle latency from SEL/commit change.
//   During a run, DATA continues to show the previous committed set.
//  All arithmetic unsigned; scale*operand fits 64 bits for all W=32 inputs.
// STRUCTURE
//  calc_pkg: FSM state encoding (IDLE, MUL, DIV, STORE, COMMIT), op indices, SEL codes,
//   default scale constants.
//  Sub-module seq_div: 64/32 restoring divider with load/busy/done, quotient 64 bits.
//  calc_sequencer owns the FSM, operand mux, saturation/div0 logic and output mux.
// TESTING
//  1 Q1=100_000_000 Q2=1000 Q3=50_000_000 Q4=12_500_000, START -> VALID at +199;
//    SEL=3 DATA=1000, SEL=1 DATA=500, SEL=2 DATA=45, DIV0=0.
//  2 Q1=0 Q2=7 Q3=0 Q4=5 -> all ops div0, VALID at +7, DATA=0 for every SEL, DIV0=3'b111.
//  3 Q1=1 Q2=1000 Q3=1 Q4=0 -> freq saturates DATA=32'hFFFF_FFFF (SEL=3), duty=1000, phase=0.
//  4 START again at +50 with different Q -> ignored; VALID once at +199 with first-set results.
//  5 RST at +100 of a run -> next cycle BUSY=0, DATA=0, DIV0=0; no VALID; new START works normally.
//  6 After test 1, cycle SEL 3->1->2->0 -> DATA 1000,500,45,0, each one cycle after SEL change.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, op indices, select codes and default scales for calc_sequencer
package calc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_STORE, S_COMMIT} state_e;
  localparam logic [1:0] OP_FREQ = 2'd0, OP_DUTY = 2'd1, OP_PHASE = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd0, SEL_DUTY = 2'd1, SEL_PHASE = 2'd2, SEL_FREQ = 2'd3;
  localparam int unsigned DEF_REF_HZ = 100_000_000;
  localparam int unsigned DEF_DUTY_SCALE = 1000;
  localparam int unsigned DEF_PHASE_SCALE = 180;
endpackage

// File: rtl/seq_div.sv
// seq_div: 2W/W restoring divider, one quotient bit per cycle, MSB first
module seq_div #(
  parameter int unsigned W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic [2*W-1:0] num_i,
  input  logic [W-1:0]   den_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] quot_o
);
  localparam int unsigned CW = $clog2(2 * W) + 1;
  logic [W-1:0]   rem_q, den_q;
  logic [2*W-1:0] quot_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     trial;
  logic           fits;
  // Dividend bits shift out of quot_q's top as quotient bits shift in at the bottom
  assign trial  = {rem_q, quot_q[2*W-1]};
  assign fits   = trial >= {1'b0, den_q};
  assign busy_o = cnt_q != '0;
  assign done_o = cnt_q == CW'(1);
  assign quot_o = quot_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      den_q  <= den_i;
      quot_q <= num_i;
      cnt_q  <= CW'(2 * W);
    end else if (busy_o) begin
      rem_q  <= fits ? W'(trial - {1'b0, den_q}) : trial[W-1:0];
      quot_q <= {quot_q[2*W-2:0], fits};
      cnt_q  <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: sequential freq/duty/phase math through one shared serial divider
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned REF_HZ      = DEF_REF_HZ,
  parameter int unsigned DUTY_SCALE  = DEF_DUTY_SCALE,
  parameter int unsigned PHASE_SCALE = DEF_PHASE_SCALE
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] q1_i,
  input  logic [W-1:0] q2_i,
  input  logic [W-1:0] q3_i,
  input  logic [W-1:0] q4_i,
  input  logic [1:0]   sel_i,
  output logic [W-1:0] data_o,
  output logic         busy_o,
  output logic         valid_o,
  output logic [2:0]   div0_o
);
  state_e         state_q;
  logic [1:0]     op_q;
  logic [W-1:0]   q1_q, q2_q, q3_q, q4_q;
  logic [W-1:0]   res_q [0:2];
  logic [W-1:0]   com_q [0:2];
  logic [2:0]     dz_q, cdz_q;
  logic [W-1:0]   data_q;
  logic           busy_q, valid_q;
  logic [W-1:0]   scale, oper, den, res_d, data_d;
  logic [2*W-1:0] num, quot;
  logic           load, div_busy, div_done;
  assign scale = op_q == OP_FREQ ? W'(REF_HZ) : op_q == OP_DUTY ? W'(DUTY_SCALE) : W'(PHASE_SCALE);
  assign oper  = op_q == OP_FREQ ? q2_q : op_q == OP_DUTY ? q3_q : q4_q;
  assign den   = op_q == OP_PHASE ? q3_q : q1_q;
  assign num   = (2 * W)'(scale) * (2 * W)'(oper);
  assign load  = state_q == S_MUL && den != '0;
  assign res_d = dz_q[op_q] ? '0 : |quot[2*W-1:W] ? '1 : quot[W-1:0];
  assign data_d = sel_i == SEL_FREQ ? com_q[0] : sel_i == SEL_DUTY ? com_q[1] :
                  sel_i == SEL_PHASE ? com_q[2] : '0;
  seq_div #(.W(W)) u_div (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load), .num_i(num), .den_i(den),
    .busy_o(div_busy), .done_o(div_done), .quot_o(quot)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_FREQ;
      {q1_q, q2_q, q3_q, q4_q} <= '0;
      res_q   <= '{default: '0};
      com_q   <= '{default: '0};
      dz_q    <= '0;
      cdz_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          {q1_q, q2_q, q3_q, q4_q} <= {q1_i, q2_i, q3_i, q4_i};
          op_q    <= OP_FREQ;
          dz_q    <= '0;
          busy_q  <= 1'b1;
          state_q <= S_MUL;
        end
        S_MUL: begin
          dz_q[op_q] <= den == '0;
          state_q    <= den == '0 ? S_STORE : S_DIV;
        end
        S_DIV: if (div_done || !div_busy) state_q <= S_STORE;
        S_STORE: begin
          res_q[op_q] <= res_d;
          // The last op's result bypasses res_q so commit lands with VALID
          if (op_q == OP_PHASE) begin
            com_q   <= '{res_q[0], res_q[1], res_d};
            cdz_q   <= dz_q;
            valid_q <= 1'b1;
            state_q <= S_COMMIT;
          end else begin
            op_q    <= op_q + 2'd1;
            state_q <= S_MUL;
          end
        end
        S_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign data_o  = data_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign div0_o  = cdz_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and randomized checks of calc_sequencer against an arithmetic model
module tb_calc_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] q1 = '0, q2 = '0, q3 = '0, q4 = '0;
  logic [1:0]  sel = 2'd3;
  logic [31:0] data;
  logic        busy, valid;
  logic [2:0]  div0;
  int n_cmp = 0, n_err = 0, cyc = 0;

  typedef struct {
    logic [31:0] f, d, p;
    logic [2:0]  z;
    int          lat;
  } exp_t;

  calc_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .q1_i(q1), .q2_i(q2), .q3_i(q3), .q4_i(q4),
    .sel_i(sel), .data_o(data), .busy_o(busy), .valid_o(valid), .div0_o(div0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ratio(input longint unsigned scale, input logic [31:0] n,
                                        input logic [31:0] dv, output bit z);
    longint unsigned q;
    z = dv == 0;
    if (z) return 32'd0;
    q = (scale * longint'(n)) / longint'(dv);
    return q > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  function automatic exp_t model(input logic [31:0] a, b, c, d);
    exp_t e;
    bit z0, z1, z2;
    e.f = ratio(100_000_000, b, a, z0);
    e.d = ratio(1000, c, a, z1);
    e.p = ratio(180, d, c, z2);
    e.z = {z2, z1, z0};
    e.lat = 199 - 64 * (int'(z0) + int'(z1) + int'(z2));
    return e;
  endfunction

  task automatic launch(input logic [31:0] a, b, c, d);
    q1 = a; q2 = b; q3 = c; q4 = d;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid(input string tag, input int lat);
    while (!valid && cyc < 400) begin
      step();
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
  endtask

  task automatic check_set(input string tag, input exp_t e);
    chk({tag, " div0"}, {29'd0, div0}, {29'd0, e.z});
    step();
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, " valid_pulse"}, {31'd0, valid}, 32'd0);
    sel = 2'd3; step(); chk({tag, " freq"}, data, e.f);
    sel = 2'd1; step(); chk({tag, " duty"}, data, e.d);
    sel = 2'd2; step(); chk({tag, " phase"}, data, e.p);
    sel = 2'd0; step(); chk({tag, " zero"}, data, 32'd0);
    sel = 2'd3;
  endtask

  task automatic run(input string tag, input logic [31:0] a, b, c, d);
    exp_t e;
    e = model(a, b, c, d);
    launch(a, b, c, d);
    chk({tag, " busy_start"}, {31'd0, busy}, 32'd1);
    wait_valid(tag, e.lat);
    check_set(tag, e);
  endtask

  initial begin
    exp_t e;
    int vcount;
    logic [31:0] a, b, c, d;
    repeat (3) step();
    chk("reset data", data, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset div0", {29'd0, div0}, 32'd0);
    rst = 1'b0;
    step();

    run("t1", 32'd100_000_000, 32'd1000, 32'd50_000_000, 32'd12_500_000);
    run("t2", 32'd0, 32'd7, 32'd0, 32'd5);
    run("t3", 32'd1, 32'd1000, 32'd1, 32'd0);

    e = model(32'd100_000_000, 32'd1000, 32'd50_000_000, 32'd12_500_000);
    launch(32'd100_000_000, 32'd1000, 32'd50_000_000, 32'd12_500_000);
    while (cyc < 50) begin step(); cyc++; end
    q1 = 32'd3; q2 = 32'd99; q3 = 32'd0; q4 = 32'd77;
    start = 1'b1; step(); cyc++; start = 1'b0;
    wait_valid("t4", e.lat);
    check_set("t4", e);
    vcount = 0;
    repeat (250) begin step(); vcount += int'(valid); end
    chk("t4 no_second_valid", 32'(vcount), 32'd0);

    launch(32'd1000, 32'd5, 32'd500, 32'd100);
    while (cyc < 100) begin step(); cyc++; end
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5 busy", {31'd0, busy}, 32'd0);
    chk("t5 data", data, 32'd0);
    chk("t5 div0", {29'd0, div0}, 32'd0);
    vcount = 0;
    repeat (250) begin step(); vcount += int'(valid); end
    chk("t5 no_valid", 32'(vcount), 32'd0);
    run("t5 restart", 32'd100_000_000, 32'd1000, 32'd50_000_000, 32'd12_500_000);

    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom_range(0, 1) == 0 ? $urandom_range(1, 200) : $urandom;
      b = $urandom;
      c = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom;
      d = $urandom;
      run($sformatf("rnd%0d", i), a, b, c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
